// File: rtl/pool_window_buffer.sv
// 2x2 stride-2 window gatherer for a max-pooling stage: buffers the even row of each
// row pair and emits a packed {bottom-right, bottom-left, top-right, top-left} window per odd column.
`timescale 1ns/1ps

module pool_window_buffer #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [4*WIDTH-1:0] win_data,
    output logic               frame_done
);

    localparam int KERNEL_SIZE = 4;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_ODD_MASK = ~COL_W'(1);

    typedef enum logic {
        FILL_TOP,
        FILL_BOT
    } state_t;

    state_t                       state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [WIDTH-1:0]             hold_q, hold_d;
    logic                         win_valid_q, win_valid_d;
    logic [KERNEL_SIZE*WIDTH-1:0] win_data_q, win_data_d;
    logic                         frame_done_q, frame_done_d;
    logic [WIDTH-1:0]             line_q [IMG_W];

    logic accept;
    logic load;
    logic line_we;
    logic col_last;
    logic row_last;

    assign in_ready   = !win_valid_q || win_ready;
    assign accept     = in_valid && in_ready;
    assign col_last   = (col_q == COL_LAST);
    assign row_last   = (row_q == ROW_LAST);
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        win_valid_d  = win_valid_q;
        win_data_d   = win_data_q;
        line_we      = 1'b0;
        load         = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d   = '0;
                row_d   = row_last ? '0 : row_q + 1'b1;
                state_d = (state_q == FILL_TOP) ? FILL_BOT : FILL_TOP;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (state_q == FILL_TOP) begin
                line_we = 1'b1;
            end else if (!col_q[0]) begin
                hold_d = in_data;
            end else begin
                load = 1'b1;
            end
        end

        frame_done_d = load && row_last && col_last;

        // A fresh load wins over consumption so back-to-back windows keep win_valid high.
        if (load) begin
            win_valid_d = 1'b1;
            win_data_d  = {in_data, hold_q, line_q[col_q], line_q[col_q & COL_ODD_MASK]};
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL_TOP;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer is deliberately left out of reset; every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[col_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer on a 4x4 map: frame-level scoreboard of expected windows
// plus a table of corner-value windows, backpressure, back-to-back frames and mid-frame reset.
`timescale 1ns/1ps

module tb_pool_window_buffer;

    localparam int WIDTH = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic               win_valid;
    logic               win_ready = 1'b1;
    logic [4*WIDTH-1:0] win_data;
    logic               frame_done;

    typedef struct {
        logic [4*WIDTH-1:0] data;
        logic               fd;
        int                 cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0]   tl, tr, bl, br;
        logic [4*WIDTH-1:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[4];

    logic [WIDTH-1:0]   frame[NPIX];
    bit                 use_override = 1'b0;
    logic [4*WIDTH-1:0] override_exp = '0;

    int checks   = 0;
    int errors   = 0;
    int cycle    = 0;
    int fd_count = 0;
    bit prev_valid = 1'b0;
    bit prev_taken = 1'b0;

    pool_window_buffer #(
        .WIDTH(WIDTH),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Monitor: pops one expectation on the first cycle of every window, then checks it stays stable.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (win_valid && (!prev_valid || prev_taken)) begin
                if (sb.size() == 0) begin
                    fail("unexpected_window", $sformatf("got window %h, required no window", win_data));
                end else begin
                    cur = sb.pop_front();
                    check("win_data", win_data, cur.data);
                    check("frame_done", {31'b0, frame_done}, {31'b0, cur.fd});
                    check("win_latency", cycle, cur.cyc);
                    if (frame_done) fd_count++;
                end
            end else if (win_valid) begin
                check("win_hold", win_data, cur.data);
                check("frame_done_hold", {31'b0, frame_done}, 32'd0);
            end else begin
                check("frame_done_idle", {31'b0, frame_done}, 32'd0);
            end
            prev_valid = win_valid;
            prev_taken = win_valid && win_ready;
        end
    end

    task automatic record(input int idx);
        exp_t e;
        int   r, c;
        r = idx / IMG_W;
        c = idx % IMG_W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.data = {frame[idx], frame[idx-1], frame[idx-IMG_W], frame[idx-IMG_W-1]};
            if (use_override && idx == IMG_W + 1) e.data = override_exp;
            e.fd  = (idx == NPIX - 1);
            e.cyc = cycle;
            sb.push_back(e);
        end
    endtask

    // Entered and left at posedge+1; the accept happens on the posedge in between.
    task automatic send_pixel(input logic [WIDTH-1:0] v, input int idx, input bit gap);
        int waitc = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout", "got in_ready=0 for 200 cycles, required 1");
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        record(idx);
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input bit gap, input int n);
        for (int i = 0; i < n; i++) send_pixel(frame[i], i, gap);
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < NPIX; i++) frame[i] = WIDTH'(base + i);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || win_valid) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("queue_drained", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_win_valid", {31'b0, win_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_win_valid", {31'b0, win_valid}, 32'd0);
        check("post_rst_win_data", win_data, 32'd0);
        check("post_rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish by 2 ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 32'h00FF7F80};
        vecs[1] = '{8'h01, 8'h02, 8'h05, 8'h06, 32'h06050201};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h00, 8'h80, 8'h01, 8'h7F, 32'h7F018000};

        @(posedge clk); #1;
        do_reset();

        $display("[TB] streaming 1..16 with win_ready=1");
        fd_count = 0;
        fill_seq(1);
        send_frame(1'b0, NPIX);
        drain();
        check("fd_count_single", fd_count, 32'd1);

        $display("[TB] backpressure after first window");
        fd_count = 0;
        fill_seq(1);
        fork
            send_frame(1'b0, NPIX);
            begin
                int t = 0;
                do begin
                    @(posedge clk); #1;
                    t++;
                end while (!win_valid && t < 100);
                if (!win_valid) fail("stall_wait", "got win_valid=0 for 100 cycles, required 1");
                win_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    check("stall_data", win_data, 32'h06050201);
                    @(posedge clk); #1;
                end
                win_ready = 1'b1;
            end
        join
        drain();
        check("fd_count_stall", fd_count, 32'd1);

        $display("[TB] toggling in_valid then back-to-back frame");
        fd_count = 0;
        fill_seq(1);
        send_frame(1'b1, NPIX);
        fill_seq(17);
        send_frame(1'b0, NPIX);
        drain();
        check("fd_count_two_frames", fd_count, 32'd2);

        $display("[TB] reset with a pending window");
        win_ready = 1'b0;
        fill_seq(1);
        send_frame(1'b0, 6);
        @(negedge clk);
        check("pending_before_rst", {31'b0, win_valid}, 32'd1);
        @(posedge clk); #1;
        do_reset();
        win_ready = 1'b1;
        fd_count  = 0;
        send_frame(1'b0, NPIX);
        drain();
        check("fd_count_after_rst", fd_count, 32'd1);

        $display("[TB] corner-value window table");
        for (int v = 0; v < 4; v++) begin
            fill_seq(8'h20);
            frame[0]         = vecs[v].tl;
            frame[1]         = vecs[v].tr;
            frame[IMG_W]     = vecs[v].bl;
            frame[IMG_W + 1] = vecs[v].br;
            use_override     = 1'b1;
            override_exp     = vecs[v].exp;
            send_frame(1'b0, NPIX);
            drain();
            use_override = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_window_buffer.md
POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, activation bit width (two's complement).
REQ-002 SHALL have parameter IMG_W, default 8, pixels per feature-map row; even, >= 2.
REQ-003 SHALL have parameter IMG_H, default 8, rows per feature map; even, >= 2.
REQ-004 SHALL fix pooling to 2x2, stride 2, non-overlapping; KERNEL_SIZE = 4, internal only.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, in_data holds a valid pixel.
REQ-008 SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-009 SHALL have port in_data, input, WIDTH, pixel value, raster order (row-major, column 0 first).
REQ-010 SHALL have port win_valid, output, 1, win_data holds a complete window.
REQ-011 SHALL have port win_ready, input, 1, consumer takes the window this cycle.
REQ-012 SHALL have port win_data, output, 4*WIDTH, packed window, matching the max-pooling stage activations input (POOLING_NxN=2).
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse marking the final window of a frame.

Function
REQ-014 SHALL accept a pixel only when in_valid && in_ready ("accept"); cycles without an accept change no counter or state.
REQ-015 SHALL drive in_ready = !win_valid || win_ready (combinational); no pixel is dropped or duplicated under backpressure.
REQ-016 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1); col increments per accept, wraps to 0 at IMG_W-1 and increments row; row wraps to 0 at IMG_H-1, starting the next frame with no idle cycle.
REQ-017 SHALL run a two-state FSM: FILL_TOP (even row) and FILL_BOT (odd row); transitions only on the accept of col = IMG_W-1: FILL_TOP->FILL_BOT, FILL_BOT->FILL_TOP.
REQ-018 In FILL_TOP, SHALL write each accepted pixel into an IMG_W-entry line buffer at index col.
REQ-019 In FILL_BOT with even col, SHALL latch the accepted pixel into a hold register.
REQ-020 In FILL_BOT with odd col c, SHALL on the accept load win_data with slice0 = line[c-1] (top-left), slice1 = line[c] (top-right), slice2 = hold (bottom-left), slice3 = in_data (bottom-right); slice k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-021 SHALL assert win_valid the cycle after the REQ-020 accept (latency 1) and hold win_valid and win_data stable until a cycle with win_valid && win_ready.
REQ-022 On win_valid && win_ready with no new window load, SHALL clear win_valid next cycle; on a simultaneous load, SHALL keep win_valid high with the new data (back-to-back windows allowed).
REQ-023 SHALL pass values bit-exact with no sign extension, saturation or arithmetic.
REQ-024 SHALL pulse frame_done high for exactly one cycle, coincident with the first cycle of win_valid for the window loaded by the accept at row IMG_H-1, col IMG_W-1.
REQ-025 SHALL produce (IMG_W/2)*(IMG_H/2) windows per frame, in raster order of window position.
REQ-026 SHALL never read a line-buffer entry before it is written in the current row pair.

Reset
REQ-027 While rst is high, SHALL force win_valid=0, win_data=0, frame_done=0, col=0, row=0, FSM=FILL_TOP, hold=0; in_ready therefore reads 1.
REQ-028 Line-buffer contents SHALL NOT be reset.
REQ-029 Reset mid-frame SHALL discard any partial frame and pending window; the first accept after rst deasserts is row 0, col 0.

Verification (WIDTH=8, IMG_W=4, IMG_H=4)
REQ-030 Assert rst for 2 cycles, release -> win_valid=0, win_data=0, frame_done=0, in_ready=1.
REQ-031 Stream pixels 1..16 every cycle, win_ready=1 -> windows {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16} (slice0..3), each one cycle after accepting 6, 8, 14 and 16; frame_done with the last window only.
REQ-032 Same stream, win_ready=0 for 5 cycles after the first window -> in_ready=0, win_data holds {1,2,5,6}; after release, remaining windows are identical to REQ-031 with no loss.
REQ-033 Pixels 8'h80, 8'h7F, 8'hFF, 8'h00 as one window -> win_data = 32'h00FF7F80.
REQ-034 in_valid toggling 1/0 over 16 pixels, then a second back-to-back frame 17..32 -> REQ-031 windows, then {17,18,21,22}..{27,28,31,32}, with two frame_done pulses total.
REQ-035 Assert rst after 6 accepts (first window pending, win_ready=0), then send 1..16 -> no stale window; output matches REQ-031 exactly.
